// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
// Module : sevseg_pkg
// Brief  : Shared constants for the multiplexed seven-segment driver.
// Rev    : 1.0
// ============================================================================
package sevseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex nibbles 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int thr_width(input int refresh_div, input int dim_bits);
        return $clog2(refresh_div) + dim_bits + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevseg_mux_n_if.sv
`default_nettype none
// ============================================================================
// Module : sevseg_mux_n_if
// Brief  : Display data inputs and multiplexed pad outputs of sevseg_mux_n.
// Rev    : 1.0
// ============================================================================
interface sevseg_mux_n_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIM_BITS   = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz_suppress;
    logic [DIM_BITS-1:0]     brightness;
    logic [NUM_DIGITS-1:0]   IO_SSEG_SEL;
    logic [6:0]              IO_SSEG;
    logic                    IO_SSEG_DP;
    logic                    frame_tick;

    modport master (
        output digits, dp_in, blank, lz_suppress, brightness,
        input  IO_SSEG_SEL, IO_SSEG, IO_SSEG_DP, frame_tick
    );

    modport slave (
        input  digits, dp_in, blank, lz_suppress, brightness,
        output IO_SSEG_SEL, IO_SSEG, IO_SSEG_DP, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/sevseg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module : sevseg_hex_decode
// Brief  : Combinational hex nibble to active-low seven-segment pattern.
// Rev    : 1.0
// ============================================================================
module sevseg_hex_decode
    import sevseg_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_seg
);
    assign o_seg = SEG_TABLE[i_nibble];
endmodule
`default_nettype wire

// File: rtl/sevseg_mux_n.sv
`default_nettype none
// ============================================================================
// Module : sevseg_mux_n
// Brief  : N-digit time-multiplexed seven-segment driver with frame snapshot,
//          leading-zero suppression and PWM dimming.
// Rev    : 1.0
// ============================================================================
module sevseg_mux_n
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIM_BITS    = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    sevseg_mux_n_if.slave bus
);
    localparam int c_cnt_w = $clog2(REFRESH_DIV);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_thr_w = thr_width(REFRESH_DIV, DIM_BITS);

    logic [c_cnt_w-1:0]      r_slot_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_snap_digits;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_blank;
    logic                    r_snap_lz;
    logic [DIM_BITS-1:0]     r_snap_bright;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic [6:0]              r_sseg;
    logic                    r_dp;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_lz_dark;
    logic [3:0]              w_nibble;
    logic                    w_blank_cur;
    logic                    w_lz_cur;
    logic                    w_dp_cur;
    logic [NUM_DIGITS-1:0]   w_sel_lit;
    logic [6:0]              w_seg;
    logic [c_thr_w-1:0]      w_bright_p1;
    logic [c_thr_w-1:0]      w_thr;
    logic                    w_pwm_on;
    logic                    w_lit;

    assign w_slot_end  = (r_slot_cnt == c_cnt_w'(REFRESH_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == c_idx_w'(NUM_DIGITS - 1));

    // A digit is a leading zero when it and every more significant nibble are 0.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_first
            assign w_lz_dark[gi] = 1'b0;
        end else begin : g_upper
            assign w_lz_dark[gi] = r_snap_lz &&
                (r_snap_digits[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end

    always_comb begin
        w_nibble    = 4'h0;
        w_blank_cur = 1'b0;
        w_lz_cur    = 1'b0;
        w_dp_cur    = 1'b0;
        w_sel_lit   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nibble     = r_snap_digits[4*i +: 4];
                w_blank_cur  = r_snap_blank[i];
                w_lz_cur     = w_lz_dark[i];
                w_dp_cur     = r_snap_dp[i];
                w_sel_lit[i] = 1'b0;
            end
        end
    end

    // Widened so (2**DIM_BITS)*REFRESH_DIV fits before the shift.
    assign w_bright_p1 = c_thr_w'(r_snap_bright) + c_thr_w'(1);
    assign w_thr       = (w_bright_p1 * c_thr_w'(REFRESH_DIV)) >> DIM_BITS;
    assign w_pwm_on    = c_thr_w'(r_slot_cnt) < w_thr;
    assign w_lit       = w_pwm_on && !w_blank_cur && !w_lz_cur;

    sevseg_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt    <= '0;
            r_idx         <= '0;
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
            r_snap_blank  <= '0;
            r_snap_lz     <= 1'b0;
            r_snap_bright <= '0;
            r_sel         <= '1;
            r_sseg        <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_frame_tick  <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == c_idx_w'(NUM_DIGITS - 1)) ? '0 : r_idx + c_idx_w'(1);
            end else begin
                r_slot_cnt <= r_slot_cnt + c_cnt_w'(1);
            end

            if (w_frame_end) begin
                r_snap_digits <= bus.digits;
                r_snap_dp     <= bus.dp_in;
                r_snap_blank  <= bus.blank;
                r_snap_lz     <= bus.lz_suppress;
                r_snap_bright <= bus.brightness;
            end
            r_frame_tick <= w_frame_end;

            if (w_lit) begin
                r_sel  <= w_sel_lit;
                r_sseg <= w_seg;
                r_dp   <= ~w_dp_cur;
            end else begin
                r_sel  <= '1;
                r_sseg <= SEG_BLANK;
                r_dp   <= 1'b1;
            end
        end
    end

    assign bus.IO_SSEG_SEL = r_sel;
    assign bus.IO_SSEG     = r_sseg;
    assign bus.IO_SSEG_DP  = r_dp;
    assign bus.frame_tick  = r_frame_tick;

endmodule
`default_nettype wire

// File: doc/sevseg_mux_n.md
SEVSEG_MUX_N -- requirements
Module: sevseg_mux_n

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; legal only if REFRESH_DIV >= 2**DIM_BITS.
REQ-003 Parameter DIM_BITS, default 4: width of the brightness input.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 digits  in  4*NUM_DIGITS  packed hex nibbles; nibble i = bits [4i+3:4i] = digit i (digit 0 rightmost, least significant).
REQ-007 dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-008 blank  in  NUM_DIGITS  force digit i dark, active-high.
REQ-009 lz_suppress  in  1  enable leading-zero suppression.
REQ-010 brightness  in  DIM_BITS  PWM duty code; all-ones = full on.
REQ-011 IO_SSEG_SEL  out  NUM_DIGITS  digit select, active-low, bit i = digit i.
REQ-012 IO_SSEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 IO_SSEG_DP  out  1  decimal point, active-low.
REQ-014 frame_tick  out  1  one-cycle pulse at end of each full scan frame.

Function
REQ-015 slot_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, idx SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-016 In the cycle where slot_cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1, the block SHALL capture digits, dp_in, blank, lz_suppress and brightness into a snapshot, and SHALL assert frame_tick in the following cycle for exactly one cycle.
REQ-017 All display decisions SHALL use only snapshot values; input changes mid-frame SHALL NOT appear until the next frame (no tearing).
REQ-018 Outputs SHALL be registered: outputs in cycle t+1 reflect idx/slot_cnt/snapshot at cycle t (latency 1).
REQ-019 Decode SHALL map nibble 0..F to the standard active-low patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 Leading-zero: with snapshot lz_suppress=1, digit i (i>0) SHALL be dark if its nibble and all nibbles j>i are 0; digit 0 SHALL never be suppressed.
REQ-021 PWM: thr = ((brightness+1)*REFRESH_DIV) >> DIM_BITS, computed at width clog2(REFRESH_DIV)+DIM_BITS+1 without truncation; the digit is lit only while slot_cnt < thr.
REQ-022 A lit digit SHALL drive IO_SSEG_SEL bit idx low and all others high, IO_SSEG = decode, IO_SSEG_DP = ~dp.
REQ-023 A dark digit (blank, suppressed or PWM off) SHALL drive IO_SSEG_SEL all ones, IO_SSEG 7'h7F, IO_SSEG_DP 1; blank takes precedence over dp.
REQ-024 At no cycle SHALL more than one IO_SSEG_SEL bit be low.

Reset
REQ-025 While rst=1 at a clock edge: slot_cnt=0, idx=0, snapshot all zero (brightness 0, lz 0), IO_SSEG_SEL all ones, IO_SSEG 7'h7F, IO_SSEG_DP 1, frame_tick 0.
REQ-026 Reset asserted mid-frame SHALL abort the scan; the first post-reset frame displays zeros until the first snapshot.

Structure
REQ-027 Package sevseg_pkg SHALL hold the 16-entry segment constant table, SEG_BLANK (7'h7F) and the PWM threshold width function.
REQ-028 One combinational sub-module sevseg_hex_decode (4-bit nibble -> 7-bit active-low pattern) SHALL be instantiated once.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, DIM_BITS=3)
REQ-029 Reset, digits=16'h12AF, brightness=7 -> after first frame_tick, slots idx0..3 show SEL 1110/1101/1011/0111 with SSEG 0001110/0001000/0100100/1111001, each lit 8 cycles.
REQ-030 brightness=3 -> per slot SEL active for exactly 4 of 8 cycles, dark the other 4; brightness=0 -> active 1 of 8.
REQ-031 digits=16'h0050, lz_suppress=1 -> digits 3 and 2 dark, digit 1 shows 0010010, digit 0 shows 1000000; digits=16'h0000 -> only digit 0 lit showing 1000000.
REQ-032 Change digits from 16'h1111 to 16'h2222 while idx=1 -> remainder of frame still shows 1111001; next frame shows 0100100.
REQ-033 blank=4'b0100, dp_in=4'b0101 -> digit 2 dark with IO_SSEG_DP=1; digit 0 lit with IO_SSEG_DP=0.
REQ-034 Assert rst for 1 cycle at idx=2, slot_cnt=5 -> next cycle outputs at reset values, slot_cnt restarts at 0 with idx 0; frame_tick period 32 cycles thereafter.
